// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per enabled clock, framing strobes.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
  localparam int LAST_CNT = WIDTH;
`else
  localparam int LAST_CNT = WIDTH - 1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               load_ready_q, load_ready_d;
`ifdef PISO_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      load_ready_q  <= 1'b1;
`ifdef PISO_TX_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      load_ready_q  <= load_ready_d;
`ifdef PISO_TX_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  // NOTE: every next-state value defaults to "hold" first, so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    done_d        = done_q;
    busy_d        = busy_q;
    load_ready_d  = load_ready_q;
`ifdef PISO_TX_PARITY_EN
    par_d         = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        // bit_en is deliberately ignored here so the first bit always gets a full cycle.
        if (load_valid && load_ready_q) begin
          state_d       = SHIFT;
          shreg_d       = load_data;
          cnt_d         = '0;
          ser_out_d     = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          load_ready_d  = 1'b0;
          busy_d        = 1'b1;
`ifdef PISO_TX_PARITY_EN
          par_d         = ^load_data;
`endif
        end
      end

      SHIFT: begin
        if (bit_en) begin
          frame_start_d = 1'b0;
          if (cnt_q == CNT_W'(LAST_CNT)) begin
            state_d     = DONE;
            ser_valid_d = 1'b0;
            ser_out_d   = 1'b0;
            done_d      = 1'b1;
          end
`ifdef PISO_TX_PARITY_EN
          else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            ser_out_d = par_q;
            cnt_d     = cnt_q + CNT_W'(1);
          end
`endif
          else begin
            // The register keeps the bit on the line in its end position; the next one sits beside it.
            if (MSB_FIRST) begin
              ser_out_d = shreg_q[WIDTH-2];
              shreg_d   = shreg_q << 1;
            end else begin
              ser_out_d = shreg_q[1];
              shreg_d   = shreg_q >> 1;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d      = IDLE;
        cnt_d        = '0;
        done_d       = 1'b0;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready  = load_ready_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance share one stimulus stream.
// Status vectors are packed as {load_ready, ser_valid, ser_out, frame_start, done, busy}.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       load_valid;
  logic [7:0] load_data;

  logic m_load_ready, m_ser_out, m_ser_valid, m_frame_start, m_done, m_busy;
  logic l_load_ready, l_ser_out, l_ser_valid, l_frame_start, l_done, l_busy;
  logic [5:0] m_st, l_st;

  int checks = 0;
  int errors = 0;

`ifdef PISO_TX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam int PERIOD = NBITS + 2;

  localparam logic [5:0] ST_IDLE = 6'b100000;
  localparam logic [5:0] ST_DONE = 6'b000011;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_load_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .frame_start(m_frame_start), .done(m_done), .busy(m_busy)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_load_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .frame_start(l_frame_start), .done(l_done), .busy(l_busy)
  );

  assign m_st = {m_load_ready, m_ser_valid, m_ser_out, m_frame_start, m_done, m_busy};
  assign l_st = {l_load_ready, l_ser_valid, l_ser_out, l_frame_start, l_done, l_busy};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n      = 1'b0;
    bit_en     = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (m_st !== ST_IDLE || l_st !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_hold: msb %b lsb %b want %b", m_st, l_st, ST_IDLE);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (m_st !== ST_IDLE || l_st !== ST_IDLE) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: msb %b lsb %b want %b", i, m_st, l_st, ST_IDLE);
      end
    end
  endtask

  // Entered and left at a falling edge with both transmitters idle; bit_en held at 1.
  task automatic send_frame(input logic [7:0] word, input logic exp_par, input string tag);
    logic [5:0] m_exp, l_exp;
    load_valid = 1'b1;
    load_data  = word;
    bit_en     = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = ~word;
    for (int k = 0; k < 8; k++) begin
      m_exp = {1'b0, 1'b1, word[7-k], (k == 0), 1'b0, 1'b1};
      l_exp = {1'b0, 1'b1, word[k],   (k == 0), 1'b0, 1'b1};
      checks++;
      if (m_st !== m_exp || l_st !== l_exp) begin
        errors++;
        $display("FAIL %s bit%0d: msb %b lsb %b want %b / %b", tag, k, m_st, l_st, m_exp, l_exp);
      end
      @(negedge clk);
    end
`ifdef PISO_TX_PARITY_EN
    m_exp = {1'b0, 1'b1, exp_par, 1'b0, 1'b0, 1'b1};
    checks++;
    if (m_st !== m_exp || l_st !== m_exp) begin
      errors++;
      $display("FAIL %s parity: msb %b lsb %b want %b", tag, m_st, l_st, m_exp);
    end
    @(negedge clk);
`else
    if (exp_par === 1'bx) $display("note: %s parity argument unknown", tag);
`endif
    checks++;
    if (m_st !== ST_DONE || l_st !== ST_DONE) begin
      errors++;
      $display("FAIL %s done: msb %b lsb %b want %b", tag, m_st, l_st, ST_DONE);
    end
    @(negedge clk);
    checks++;
    if (m_st !== ST_IDLE || l_st !== ST_IDLE) begin
      errors++;
      $display("FAIL %s ready_again: msb %b lsb %b want %b", tag, m_st, l_st, ST_IDLE);
    end
  endtask

  task automatic test_basic_frame();
    send_frame(8'hA5, 1'b0, "basic_A5");
  endtask

  task automatic test_lsb_first();
    send_frame(8'h01, 1'b1, "lsb_01");
  endtask

  task automatic test_stall();
    logic [7:0] word;
    logic       en_pat [0:15];
    logic [5:0] exp;
    int         idx;
    int         done_edge;
    word   = 8'hA5;
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    idx       = 0;
    done_edge = -1;
    load_valid = 1'b1;
    load_data  = word;
    bit_en     = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (m_st !== {1'b0, 1'b1, word[7], 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL stall first_bit: got %b", m_st);
    end
    for (int j = 1; j <= 16 && done_edge < 0; j++) begin
      bit_en = en_pat[j-1];
      @(negedge clk);
      if (bit_en) idx++;
      if (idx < 8)        exp = {1'b0, 1'b1, word[7-idx], (idx == 0), 1'b0, 1'b1};
      else if (idx < NBITS) exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      else begin
        exp       = ST_DONE;
        done_edge = j;
      end
      checks++;
      if (m_st !== exp) begin
        errors++;
        $display("FAIL stall edge%0d: got %b want %b", j, m_st, exp);
      end
    end
    checks++;
    if (done_edge != NBITS + 2) begin
      errors++;
      $display("FAIL stall done_delay: done after edge %0d want %0d", done_edge, NBITS + 2);
    end
    bit_en = 1'b0;
    @(negedge clk);
    checks++;
    if (m_st !== ST_IDLE) begin
      errors++;
      $display("FAIL stall done_ignores_bit_en: got %b want %b", m_st, ST_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] word1, word2;
    int         second;
    int         j;
    word1 = 8'h00;
    word2 = 8'h00;
    second = -1;
    load_valid = 1'b1;
    load_data  = 8'h3C;
    bit_en     = 1'b1;
    j = 0;
    while (j < 40 && !(second >= 0 && j - second >= 8)) begin
      @(negedge clk);
      if (j == 0) load_data = 8'hC3;
      if (j < 8) word1[7-j] = m_ser_out;
      if (j == NBITS + 1) begin
        checks++;
        if (m_load_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b ready_after_done: got %b want 1", m_load_ready);
        end
      end
      if (m_frame_start === 1'b1 && j > 0 && second < 0) begin
        second     = j;
        load_valid = 1'b0;
      end
      if (second >= 0 && j - second < 8) word2[7-(j-second)] = m_ser_out;
      j++;
    end
    checks++;
    if (second != PERIOD) begin
      errors++;
      $display("FAIL b2b period: second accept at edge %0d want %0d", second, PERIOD);
    end
    checks++;
    if (word1 !== 8'h3C || word2 !== 8'hC3) begin
      errors++;
      $display("FAIL b2b words: got %h %h want 3c c3", word1, word2);
    end
    j = 0;
    while (j < 20 && m_st !== ST_IDLE) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (m_st !== ST_IDLE) begin
      errors++;
      $display("FAIL b2b drain: got %b want %b", m_st, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_frame();
    load_valid = 1'b1;
    load_data  = 8'h3C;
    bit_en     = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_st !== 6'b011001) begin
      errors++;
      $display("FAIL midreset bit3: got %b want 011001", m_st);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_st !== ST_IDLE || l_st !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset async: msb %b lsb %b want %b", m_st, l_st, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_st !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset idle: got %b want %b", m_st, ST_IDLE);
    end
    send_frame(8'h3C, 1'b0, "post_reset_3C");
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, "parity_07");
    send_frame(8'hA5, 1'b0, "parity_A5");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_lsb_first();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
